byte_reg_bank: RTL
==================

Name: byte_reg_bank

Overview:
- Parametrised successor to the team's 32-bit byte-loaded register memory.
- Holds DEPTH registers of WIDTH bits each, loaded one byte at a time from the 8-bit input bus.
- Two load modes:
  - Addressed mode: the host picks the register and the byte lane.
  - Streaming mode: an internal pointer FSM walks bytes and registers automatically.
- Tracks per-byte written status, so each register reports valid only after all of its bytes have been written since its last clear.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8 and ≥ 16.
- DEPTH, 4, number of registers; must be ≥ 2.
- Derived localparams: BYTES = WIDTH/8; BW = clog2(BYTES); RW = clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  byte write strobe; one byte is written per cycle while high.
- wr_data  in  8  byte to write.
- wr_reg  in  RW  target register (addressed mode only).
- wr_sel  in  BW  target byte lane, 0 = bits [7:0] (addressed mode only).
- stream_mode  in  1  1 = streaming mode, 0 = addressed mode.
- ptr_rst  in  1  synchronous reset of the stream pointers.
- clr_en  in  1  synchronous clear strobe.
- clr_reg  in  RW  register to clear.
- rd_reg  in  RW  read-select.
- rd_data  out  WIDTH  contents of register rd_reg; combinational from the register array.
- valid  out  DEPTH  bit i = 1 when every byte of register i has been written since its last clear or reset.
- byte_ptr  out  BW  next byte lane for streaming mode.
- reg_ptr  out  RW  next register for streaming mode.
- word_done  out  1  one-cycle pulse marking completion of a register in streaming mode.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All registers, written masks, byte_ptr, reg_ptr and word_done go to 0.
  - Therefore valid = 0 and rd_data = 0.
  - Reset asserted mid-stream drops any partial word.
- Addressed write (stream_mode = 0, wr_en = 1):
  - reg[wr_reg][8*wr_sel +: 8] ← wr_data; all other bytes are unchanged.
  - mask[wr_reg][wr_sel] ← 1.
  - Pointers hold.
  - An out-of-range wr_sel (≥ BYTES) or wr_reg (≥ DEPTH) is ignored: no write, no mask change.
- Streaming write (stream_mode = 1, wr_en = 1, ptr_rst = 0):
  - Write wr_data to reg[reg_ptr] at lane byte_ptr and set the matching mask bit.
  - byte_ptr increments, little-endian (byte 0 is written first).
  - When byte_ptr = BYTES-1:
    - byte_ptr wraps to 0.
    - reg_ptr increments, wrapping from DEPTH-1 to 0.
    - word_done is high for exactly the next cycle (registered pulse).
  - Back-to-back completions produce separate one-cycle pulses.
- Pointer FSM states:
  - IDLE: stream_mode = 0; pointers frozen.
  - FILL: stream_mode = 1; advances on each wr_en.
  - Switching modes neither resets nor alters the pointers.
- ptr_rst:
  - Sets byte_ptr and reg_ptr to 0 and clears any pending word_done in either mode.
  - If asserted together with a streaming write, ptr_rst wins and the write is dropped.
  - In addressed mode, the addressed write still occurs alongside ptr_rst.
- clr_en:
  - reg[clr_reg] ← 0 and mask[clr_reg] ← 0.
  - If a write in the same cycle targets the same register, the clear wins and the write is dropped.
  - A write to a different register proceeds normally.
  - Clear does not move the pointers.
- Overwrite: rewriting a byte of a valid register updates the data; valid stays 1.
- valid[i] = AND of mask[i] (purely combinational from the mask flops).
- rd_data reflects a write on the cycle after the write edge; there is no bypass.

Test Plan:
- Reset, then addressed writes wr_reg = 2, wr_sel = 0..3, data 0x11, 0x22, 0x33, 0x44 → rd_reg = 2 gives 0x44332211; valid = 4'b0100 only after the 4th write.
- Streaming: 8 consecutive writes 0xA0..0xA7 → reg0 = 0xA3A2A1A0, reg1 = 0xA7A6A5A4; word_done pulses once after each 4th write; final reg_ptr = 2, byte_ptr = 0.
- Wrap: 16 streaming bytes, then a 17th byte 0xFF → reg_ptr wraps to 0; reg0 byte 0 = 0xFF; valid stays 4'b1111.
- Collisions:
  - clr_en on reg1 in the same cycle as an addressed write to reg1 → reg1 = 0, valid[1] = 0.
  - Same clear with a write to reg3 → reg3 is updated.
- ptr_rst concurrent with a streaming write at byte_ptr = 2 → write dropped; pointers = 0; no word_done.
- rst_n pulsed low asynchronously mid-word (between clock edges) → all outputs 0 immediately; the next streaming byte lands in reg0 byte 0.

Source files
------------

// File: rtl/byte_reg_bank.sv
// Bank of DEPTH x WIDTH registers loaded one byte per cycle, either by explicit
// register/lane address or by an auto-advancing stream pointer.
module byte_reg_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [7:0]                       wr_data,
    input  logic [$clog2(DEPTH)-1:0]         wr_reg,
    input  logic [$clog2(WIDTH/8)-1:0]       wr_sel,
    input  logic                             stream_mode,
    input  logic                             ptr_rst,
    input  logic                             clr_en,
    input  logic [$clog2(DEPTH)-1:0]         clr_reg,
    input  logic [$clog2(DEPTH)-1:0]         rd_reg,
    output logic [WIDTH-1:0]                 rd_data,
    output logic [DEPTH-1:0]                 valid,
    output logic [$clog2(WIDTH/8)-1:0]       byte_ptr,
    output logic [$clog2(DEPTH)-1:0]         reg_ptr,
    output logic                             word_done
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned BW    = $clog2(BYTES);
    localparam int unsigned RW    = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StFill} mode_e;

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] mem_d  [DEPTH];
    logic [BYTES-1:0] mask_q [DEPTH];
    logic [BYTES-1:0] mask_d [DEPTH];

    logic [BW-1:0] byte_ptr_q, byte_ptr_d;
    logic [RW-1:0] reg_ptr_q, reg_ptr_d;
    logic          word_done_q, word_done_d;

    mode_e         mode;
    logic          stream_wr;
    logic          addr_wr;
    logic          do_wr;
    logic [RW-1:0] tgt_reg;
    logic [BW-1:0] tgt_sel;

    always_comb begin
        mode      = stream_mode ? StFill : StIdle;
        stream_wr = (mode == StFill) && wr_en && !ptr_rst;
        addr_wr   = (mode == StIdle) && wr_en &&
                    (int'(wr_reg) < int'(DEPTH)) && (int'(wr_sel) < int'(BYTES));
        do_wr     = stream_wr || addr_wr;
        tgt_reg   = (mode == StFill) ? reg_ptr_q : wr_reg;
        tgt_sel   = (mode == StFill) ? byte_ptr_q : wr_sel;
    end

    // Clear is applied after the write so a same-register collision drops the write.
    always_comb begin
        for (int r = 0; r < int'(DEPTH); r++) begin
            mem_d[r]  = mem_q[r];
            mask_d[r] = mask_q[r];
            for (int b = 0; b < int'(BYTES); b++) begin
                if (do_wr && int'(tgt_reg) == r && int'(tgt_sel) == b) begin
                    mem_d[r][8*b +: 8] = wr_data;
                    mask_d[r][b]       = 1'b1;
                end
            end
            if (clr_en && int'(clr_reg) == r) begin
                mem_d[r]  = '0;
                mask_d[r] = '0;
            end
        end
    end

    always_comb begin
        byte_ptr_d  = byte_ptr_q;
        reg_ptr_d   = reg_ptr_q;
        word_done_d = 1'b0;
        if (ptr_rst) begin
            byte_ptr_d = '0;
            reg_ptr_d  = '0;
        end else if (stream_wr) begin
            if (int'(byte_ptr_q) == int'(BYTES) - 1) begin
                byte_ptr_d  = '0;
                word_done_d = 1'b1;
                reg_ptr_d   = (int'(reg_ptr_q) == int'(DEPTH) - 1) ? '0 : reg_ptr_q + RW'(1);
            end else begin
                byte_ptr_d = byte_ptr_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_q[r]  <= '0;
                mask_q[r] <= '0;
            end
            byte_ptr_q  <= '0;
            reg_ptr_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_q[r]  <= mem_d[r];
                mask_q[r] <= mask_d[r];
            end
            byte_ptr_q  <= byte_ptr_d;
            reg_ptr_q   <= reg_ptr_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < int'(DEPTH); r++) begin
            if (int'(rd_reg) == r) rd_data = mem_q[r];
        end
        for (int r = 0; r < int'(DEPTH); r++) begin
            valid[r] = &mask_q[r];
        end
    end

    assign byte_ptr  = byte_ptr_q;
    assign reg_ptr   = reg_ptr_q;
    assign word_done = word_done_q;

endmodule
